// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store against a 64-bit byte-strobed word array.
// Latency: response valid LATENCY+1 cycles after the accept edge; next accept one IDLE cycle after the response handshake.
// Backpressure: o_ReqReady only in IDLE; response held stable until i_RspReady, so one request is in flight at most.
//
// Ports:
//   i_Clock, i_Reset             rising-edge clock, synchronous active-high reset
//   i_ReqValid/o_ReqReady        request handshake; i_ReqWrite, i_ReqAddr, i_ReqWData, i_ReqStrb captured on accept
//   o_RspValid/i_RspReady        response handshake; o_RspRData (load data) and o_RspError (misaligned/out of range)
module dmem_responder #(
  parameter int          DEPTH_WORDS = 512,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  input  logic        i_ReqWrite,
  input  logic [63:0] i_ReqAddr,
  input  logic [63:0] i_ReqWData,
  input  logic [7:0]  i_ReqStrb,
  output logic        o_RspValid,
  input  logic        i_RspReady,
  output logic [63:0] o_RspRData,
  output logic        o_RspError
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) << 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  strb_q, strb_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH_WORDS];

  // Offset from the base with a borrow bit: a set borrow means the address lies below the window.
  logic [64:0]      off_full;
  logic             access_err;
  logic [IDX_W-1:0] idx;
  logic             access_now;
  logic             mem_we;

  always_comb begin
    off_full   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    access_err = (addr_q[2:0] != 3'b000) || off_full[64] || (off_full[63:0] >= SPAN);
    idx        = off_full[IDX_W+2:3];
    access_now = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    // A reset on the access edge drops the store.
    mem_we     = access_now && wr_q && !access_err && !i_Reset;
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      strb_q  <= 8'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_Clock) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (strb_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_ReqValid) begin
          wr_d    = i_ReqWrite;
          addr_d  = i_ReqAddr;
          wdata_d = i_ReqWData;
          strb_d  = i_ReqStrb;
          cnt_d   = 4'(LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          err_d   = access_err;
          rdata_d = (!wr_q && !access_err) ? mem[idx] : 64'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (i_RspReady) begin
          rdata_d = 64'd0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_ReqReady = (state_q == ST_IDLE);
    o_RspValid = (state_q == ST_RESP);
    o_RspRData = rdata_q;
    o_RspError = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int          DEPTH = 512;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h0;

  logic        clk = 1'b0;
  logic        i_Reset, i_ReqValid, i_ReqWrite, i_RspReady;
  logic [63:0] i_ReqAddr, i_ReqWData;
  logic [7:0]  i_ReqStrb;
  logic        o_ReqReady, o_RspValid, o_RspError;
  logic [63:0] o_RspRData;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .i_Clock(clk), .i_Reset(i_Reset),
    .i_ReqValid(i_ReqValid), .o_ReqReady(o_ReqReady),
    .i_ReqWrite(i_ReqWrite), .i_ReqAddr(i_ReqAddr), .i_ReqWData(i_ReqWData), .i_ReqStrb(i_ReqStrb),
    .o_RspValid(o_RspValid), .i_RspReady(i_RspReady),
    .o_RspRData(o_RspRData), .o_RspError(o_RspError)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] base_v;
  int          last_acc = 0;
  int          rdy_mode = 0;
  int          hold_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response-ready driver: 0 = always ready, 1 = random, 2 = hold off for 5 cycles of valid.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: i_RspReady = 1'b1;
      1: i_RspReady = 1'($urandom_range(0, 1));
      default: begin
        if (o_RspValid) begin
          i_RspReady = (hold_cnt >= 5);
          hold_cnt++;
        end else begin
          hold_cnt   = 0;
          i_RspReady = 1'b0;
        end
      end
    endcase
  end

  // Monitor: latency on first valid cycle, stability while stalled, data/error on handshake.
  logic        pv = 1'b0, pr = 1'b0, pe = 1'b0;
  logic [63:0] prd = 64'd0;
  bit          fresh;
  exp_t        got;
  always @(negedge clk) begin
    if (o_RspValid) begin
      fresh = !(pv && !pr);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: valid with no outstanding request, rdata %h err %b (cycle %0d)", o_RspRData, o_RspError, cyc);
      end else begin
        if (fresh) begin
          chk("rsp_latency", 64'(cyc), 64'(sbq[0].acc + LAT + 1));
        end else begin
          chk("hold_rdata", o_RspRData, prd);
          chk("hold_err", 64'(o_RspError), 64'(pe));
        end
        if (i_RspReady) begin
          got = sbq.pop_front();
          chk("rsp_rdata", o_RspRData, got.rdata);
          chk("rsp_err", 64'(o_RspError), 64'(got.err));
        end
      end
    end
    pv  = o_RspValid;
    pr  = i_RspReady;
    prd = o_RspRData;
    pe  = o_RspError;
  end

  // Reference model: byte-addressed window [base, base + DEPTH*8), aligned words only.
  task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] s, output logic [63:0] rd, output logic e);
    int wi;
    e  = (a[2:0] != 3'b000) || (a < base_v) || ((a - base_v) >= 64'(DEPTH) * 64'd8);
    rd = 64'd0;
    if (!e) begin
      wi = int'((a - base_v) / 64'd8);
      if (w) begin
        for (int b = 0; b < 8; b++)
          if (s[b]) ref_mem[wi][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd = ref_mem[wi];
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                        input bit push, input bit ovr, input logic [63:0] ox, input logic oe,
                        input bit keep_valid, input bit chk_period);
    int   n;
    exp_t e;
    logic [63:0] mrd;
    logic        merr;
    i_ReqValid = 1'b1;
    i_ReqWrite = w;
    i_ReqAddr  = a;
    i_ReqWData = d;
    i_ReqStrb  = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_ReqReady && !i_Reset) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: request at addr %h not accepted after %0d cycles", a, n);
        @(posedge clk);
        #1;
        i_ReqValid = 1'b0;
        return;
      end
    end
    e.acc = cyc + 1;
    if (chk_period) chk("accept_period", 64'(e.acc - last_acc), 64'(LAT + 3));
    last_acc = e.acc;
    if (push) begin
      model(w, a, d, s, mrd, merr);
      e.rdata = ovr ? ox : mrd;
      e.err   = ovr ? oe : merr;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      i_ReqValid = 1'b0;
      i_ReqWrite = 1'($urandom_range(0, 1));
      i_ReqAddr  = {$urandom, $urandom};
      i_ReqWData = {$urandom, $urandom};
      i_ReqStrb  = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !o_ReqReady) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still outstanding", sbq.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, 64'(o_ReqReady), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(o_RspValid), 64'd0);
    chk({tag, "_rsp_rdata"}, o_RspRData, 64'd0);
    chk({tag, "_rsp_err"}, 64'(o_RspError), 64'd0);
  endtask

  logic [63:0] ra, rd;
  logic [7:0]  rs;
  logic        rw;
  int          sel;

  initial begin
    base_v     = BASE;
    i_Reset    = 1'b1;
    i_ReqValid = 1'b0;
    i_ReqWrite = 1'b0;
    i_ReqAddr  = 64'd0;
    i_ReqWData = 64'd0;
    i_ReqStrb  = 8'd0;
    i_RspReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    i_Reset = 1'b0;

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++)
      do_req(1'b1, 64'(w) * 64'd8, {$urandom, $urandom}, 8'hFF, 1, 0, 64'd0, 1'b0, 0, 0);

    // Full store then load.
    do_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 1, 1, 64'd0, 1'b0, 0, 0);
    do_req(1'b0, 64'h10, 64'd0, 8'h00, 1, 1, 64'h1122334455667788, 1'b0, 0, 0);

    // Partial strobe over an all-ones word, and a zero-strobe store.
    do_req(1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1, 0, 64'd0, 1'b0, 0, 0);
    do_req(1'b1, 64'h20, 64'h0, 8'h0F, 1, 0, 64'd0, 1'b0, 0, 0);
    do_req(1'b0, 64'h20, 64'd0, 8'h00, 1, 1, 64'hFFFF_FFFF_0000_0000, 1'b0, 0, 0);
    do_req(1'b1, 64'h20, 64'h0, 8'h00, 1, 1, 64'd0, 1'b0, 0, 0);
    do_req(1'b0, 64'h20, 64'd0, 8'h00, 1, 1, 64'hFFFF_FFFF_0000_0000, 1'b0, 0, 0);

    // Errors: misaligned load, store just past the window, word 0 intact, last word fine.
    do_req(1'b0, 64'h13, 64'd0, 8'h00, 1, 1, 64'd0, 1'b1, 0, 0);
    do_req(1'b1, 64'(DEPTH) * 64'd8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1, 1, 64'd0, 1'b1, 0, 0);
    do_req(1'b0, 64'h0, 64'd0, 8'h00, 1, 0, 64'd0, 1'b0, 0, 0);
    do_req(1'b0, 64'(DEPTH - 1) * 64'd8, 64'd0, 8'h00, 1, 0, 64'd0, 1'b0, 0, 0);
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 8'h00, 1, 1, 64'd0, 1'b1, 0, 0);

    // Response held off for 5 cycles.
    drain();
    rdy_mode = 2;
    do_req(1'b0, 64'h10, 64'd0, 8'h00, 1, 0, 64'd0, 1'b0, 0, 0);
    do_req(1'b1, 64'h18, 64'hA5A5_5A5A_0F0F_F0F0, 8'h3C, 1, 0, 64'd0, 1'b0, 0, 0);
    do_req(1'b0, 64'h18, 64'd0, 8'h00, 1, 0, 64'd0, 1'b0, 0, 0);
    drain();
    rdy_mode = 0;

    // Continuous request valid with ready always high.
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++)
      do_req(1'($urandom_range(0, 1)), 64'($urandom_range(0, 63)) * 64'd8, {$urandom, $urandom}, 8'($urandom),
             1, 0, 64'd0, 1'b0, (k != 9), (k != 0));
    drain();

    // Reset during WAIT of a store: dropped, no response.
    do_req(1'b1, 64'h8, 64'hCAFE_F00D_CAFE_F00D, 8'hFF, 0, 0, 64'd0, 1'b0, 0, 0);
    i_Reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    i_Reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    do_req(1'b0, 64'h8, 64'd0, 8'h00, 1, 0, 64'd0, 1'b0, 0, 0);
    drain();

    // Randomized traffic with random response backpressure and withdrawn requests.
    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ra = 64'($urandom_range(0, DEPTH - 1)) * 64'd8 + 64'($urandom_range(1, 7));
        1:       ra = 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 100)) * 64'd8;
        2:       ra = {$urandom, $urandom} & ~64'h7;
        3:       ra = 64'(DEPTH - 1) * 64'd8;
        default: ra = 64'($urandom_range(0, 63)) * 64'd8;
      endcase
      rw = 1'($urandom_range(0, 1));
      rd = {$urandom, $urandom};
      rs = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_req(rw, ra, rd, rs, 1, 0, 64'd0, 1'b0, 0, 0);
      if ($urandom_range(0, 3) == 0) begin
        // Responder is in WAIT here; a withdrawn request must not be taken.
        i_ReqValid = 1'b1;
        @(posedge clk);
        #1;
        i_ReqValid = 1'b0;
      end
    end
    drain();
    rdy_mode = 0;

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
